// File: rtl/mcs4_ram_host_bridge_if.sv
// Host-command and MCS-4 RAM-bus signals of the RAM host bridge.
// The master modport is the bridge side; the slave modport is the host/RAM side.
interface mcs4_ram_host_bridge_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [7:0] cmd_addr;
   logic [3:0] cmd_wdata;
   logic       rsp_valid;
   logic [3:0] rsp_rdata;
   logic       sync;
   logic       cm_ram;
   logic [3:0] dbus_out;
   logic [3:0] dbus_in;

   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, dbus_in,
      output cmd_ready, rsp_valid, rsp_rdata, sync, cm_ram, dbus_out
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata, dbus_in,
      input  cmd_ready, rsp_valid, rsp_rdata, sync, cm_ram, dbus_out
   );
endinterface

// File: rtl/mcs4_ram_host_bridge.sv
// MCS-4 RAM bus master: runs the free 8-phase cycle, issues SRC (optionally cached)
// plus one I/O instruction per host command and returns one response per command.
module mcs4_ram_host_bridge #(
   parameter bit SRC_CACHE = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   mcs4_ram_host_bridge_if.master        bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_SRC, ST_IO} state_t;

   localparam logic [2:0] PH_M1 = 3'd3;
   localparam logic [2:0] PH_M2 = 3'd4;
   localparam logic [2:0] PH_X2 = 3'd6;
   localparam logic [2:0] PH_X3 = 3'd7;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_phase;
   logic [3:0] r_op;
   logic [7:0] r_addr;
   logic [3:0] r_wdata;
   logic [7:0] r_last_src_addr;
   logic       r_last_src_valid;
   logic       r_rsp_valid;
   logic [3:0] r_rsp_rdata;
   logic       w_cycle_end;
   logic       w_accept;
   logic       w_hit;
   logic       w_write_op;
   logic       w_io_x2;

   assign w_cycle_end   = (r_phase == PH_X3);
   assign bus.cmd_ready = (r_state == ST_IDLE || r_state == ST_IO) && w_cycle_end;
   assign w_accept      = bus.cmd_valid && bus.cmd_ready;
   assign w_hit         = SRC_CACHE && r_last_src_valid && (bus.cmd_addr == r_last_src_addr);
   assign w_write_op    = ~r_op[3];
   assign w_io_x2       = (r_state == ST_IO) && (r_phase == PH_X2);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase <= PH_X3;
         r_state <= ST_IDLE;
      end else begin
         r_phase <= r_phase + 3'd1;
         r_state <= w_state_nxt;
      end
   end

   // Transitions happen only on the X3->A1 boundary.
   always_comb begin
      w_state_nxt = r_state;
      if (w_cycle_end) begin
         if (w_accept)
            w_state_nxt = w_hit ? ST_IO : ST_SRC;
         else if (r_state == ST_SRC)
            w_state_nxt = ST_IO;
         else
            w_state_nxt = ST_IDLE;
      end
   end

   always_comb begin
      bus.dbus_out = 4'h0;
      bus.cm_ram   = 1'b0;
      case (r_phase)
         PH_M1: begin
            if (r_state == ST_SRC)     bus.dbus_out = 4'h2;
            else if (r_state == ST_IO) bus.dbus_out = 4'hE;
         end
         PH_M2: begin
            if (r_state == ST_SRC) begin
               bus.dbus_out = 4'h1;
            end else if (r_state == ST_IO) begin
               bus.dbus_out = r_op;
               bus.cm_ram   = 1'b1;
            end
         end
         PH_X2: begin
            if (r_state == ST_SRC) begin
               bus.dbus_out = r_addr[7:4];
               bus.cm_ram   = 1'b1;
            end else if (r_state == ST_IO && w_write_op) begin
               bus.dbus_out = r_wdata;
            end
         end
         PH_X3: begin
            if (r_state == ST_SRC) bus.dbus_out = r_addr[3:0];
         end
         default: ;
      endcase
   end

   // Read data is captured at the end of X2 straight into the response register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_src_valid <= 1'b0;
         r_rsp_valid      <= 1'b0;
         r_rsp_rdata      <= 4'h0;
      end else begin
         r_rsp_valid <= w_io_x2;
         if (w_io_x2)
            r_rsp_rdata <= w_write_op ? 4'h0 : bus.dbus_in;
         if (w_accept && !w_hit) begin
            r_last_src_addr  <= bus.cmd_addr;
            r_last_src_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_op    <= bus.cmd_op;
         r_addr  <= bus.cmd_addr;
         r_wdata <= bus.cmd_wdata;
      end
   end

   assign bus.sync      = w_cycle_end;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_mcs4_ram_host_bridge.sv
// Bench for mcs4_ram_host_bridge: one cached and one uncached bridge, each with a
// bus-level chip-0 RAM stand-in, checked against command-level expectations.
module tb_mcs4_ram_host_bridge;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mcs4_ram_host_bridge_if if0 ();
   mcs4_ram_host_bridge_if if1 ();

   mcs4_ram_host_bridge #(.SRC_CACHE(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.master));
   mcs4_ram_host_bridge #(.SRC_CACHE(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.master));

   // RAM stand-in, chip 0 only; follows the bus by watching sync, cm_ram and dbus_out.
   logic       sync_w [2];
   logic       cm_w   [2];
   logic [3:0] dout_w [2];
   logic [3:0] din    [2];
   logic [2:0] rphase [2] = '{3'd0, 3'd0};
   logic       src_f  [2] = '{1'b0, 1'b0};
   logic       io_f   [2] = '{1'b0, 1'b0};
   logic [7:0] raddr  [2] = '{8'h00, 8'h00};
   logic [3:0] rop    [2] = '{4'h0, 4'h0};
   logic [3:0] mm [2][64] = '{default: 4'h0};
   logic [3:0] sm [2][16] = '{default: 4'h0};

   assign sync_w[0] = if0.sync;     assign sync_w[1] = if1.sync;
   assign cm_w[0]   = if0.cm_ram;   assign cm_w[1]   = if1.cm_ram;
   assign dout_w[0] = if0.dbus_out; assign dout_w[1] = if1.dbus_out;
   assign if0.dbus_in = din[0];
   assign if1.dbus_in = din[1];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         rphase[d] <= sync_w[d] ? 3'd0 : rphase[d] + 3'd1;
         if (sync_w[d]) begin
            if (src_f[d]) raddr[d][3:0] <= dout_w[d];
            src_f[d] <= 1'b0;
            io_f[d]  <= 1'b0;
         end
         if (rphase[d] == 3'd6 && cm_w[d]) begin
            src_f[d]      <= 1'b1;
            raddr[d][7:4] <= dout_w[d];
         end
         if (rphase[d] == 3'd4 && cm_w[d]) begin
            io_f[d] <= 1'b1;
            rop[d]  <= dout_w[d];
         end
         if (rphase[d] == 3'd6 && io_f[d] && raddr[d][7:6] == 2'd0) begin
            if (rop[d] == 4'h0)
               mm[d][raddr[d][5:0]] <= dout_w[d];
            else if (rop[d][3:2] == 2'b01)
               sm[d][{raddr[d][5:4], rop[d][1:0]}] <= dout_w[d];
         end
      end
   end

   always_comb begin
      for (int d = 0; d < 2; d++) begin
         din[d] = 4'h0;
         if (rphase[d] == 3'd6 && io_f[d] && raddr[d][7:6] == 2'd0) begin
            if (rop[d] == 4'h8 || rop[d] == 4'h9 || rop[d] == 4'hB)
               din[d] = mm[d][raddr[d][5:0]];
            else if (rop[d] >= 4'hC)
               din[d] = sm[d][{raddr[d][5:4], rop[d][1:0]}];
         end
      end
   end

   // Response monitor
   int         qc0 [$];
   int         qc1 [$];
   logic [3:0] qd0 [$];
   logic [3:0] qd1 [$];
   always @(negedge clk) begin
      if (if0.rsp_valid === 1'b1) begin qc0.push_back(cyc); qd0.push_back(if0.rsp_rdata); end
      if (if1.rsp_valid === 1'b1) begin qc1.push_back(cyc); qd1.push_back(if1.rsp_rdata); end
   end

   // Command-level reference: SRC cache state and RAM contents per bridge.
   bit         cache [2] = '{1'b1, 1'b0};
   logic       lv [2];
   logic [7:0] la [2];
   logic [3:0] em [2][64];
   logic [3:0] es [2][16];

   function automatic int src_model(input int d, input logic [7:0] a);
      if (cache[d] && lv[d] && la[d] == a) return 7;
      lv[d] = 1'b1;
      la[d] = a;
      return 15;
   endfunction

   function automatic logic [3:0] mdl(input int d, input logic [3:0] op, input logic [7:0] a,
                                      input logic [3:0] w);
      logic [3:0] r;
      r = 4'h0;
      if (a[7:6] != 2'd0) return 4'h0;
      if (op == 4'h0)                          em[d][a[5:0]] = w;
      else if (op >= 4'h4 && op <= 4'h7)       es[d][{a[5:4], op[1:0]}] = w;
      else if (op == 4'h8 || op == 4'h9 || op == 4'hB) r = em[d][a[5:0]];
      else if (op >= 4'hC)                     r = es[d][{a[5:4], op[1:0]}];
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   function automatic logic rdy(input int d);
      return (d == 1) ? if1.cmd_ready : if0.cmd_ready;
   endfunction

   function automatic int qsize(input int d);
      return (d == 1) ? qc1.size() : qc0.size();
   endfunction

   task automatic drive(input int d, input logic v, input logic [3:0] op, input logic [7:0] a,
                        input logic [3:0] w);
      if0.cmd_valid = v && (d == 0);
      if1.cmd_valid = v && (d == 1);
      if0.cmd_op = op; if0.cmd_addr = a; if0.cmd_wdata = w;
      if1.cmd_op = op; if1.cmd_addr = a; if1.cmd_wdata = w;
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input int d, input logic [3:0] op, input logic [7:0] a, input logic [3:0] w,
                       output int acc);
      int n;
      n = 0;
      drive(d, 1'b1, op, a, w);
      while (!rdy(d) && n < 40) begin @(negedge clk); n++; end
      chk("accept_ready", int'(rdy(d)), 1);
      acc = rdy(d) ? cyc + 1 : -1;
      @(negedge clk);
      drive(d, 1'b0, op, a, w);
   endtask

   task automatic get_rsp(input int d, input int acc, input int lat, input logic [3:0] rd,
                          input string tag, output int rc);
      int n;
      logic [3:0] v;
      n  = 0;
      rc = -1;
      while (qsize(d) == 0 && n < 40) begin @(negedge clk); n++; end
      chk({tag, "_rsp_seen"}, int'(qsize(d) > 0), 1);
      if (qsize(d) > 0) begin
         if (d == 1) begin rc = qc1.pop_front(); v = qd1.pop_front(); end
         else        begin rc = qc0.pop_front(); v = qd0.pop_front(); end
         chk({tag, "_latency"}, rc - acc, lat);
         chk({tag, "_rdata"}, int'(v), int'(rd));
      end
   endtask

   task automatic do_cmd(input int d, input logic [3:0] op, input logic [7:0] a,
                         input logic [3:0] w, input string tag);
      int acc, el, rc;
      logic [3:0] ed;
      el = src_model(d, a);
      ed = mdl(d, op, a, w);
      send(d, op, a, w, acc);
      if (acc >= 0) get_rsp(d, acc, el, ed, tag, rc);
   endtask

   typedef struct {
      logic [3:0] op;
      logic [7:0] addr;
      logic [3:0] wd;
      int         lat;
      logic [3:0] rd;
   } vec_t;

   vec_t       tbl  [6];
   logic [5:0] wave [16];

   initial begin
      #300000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      int acc, rc, prev_rc;
      int accs [4];
      logic [7:0] ra;

      tbl[0] = '{4'h0, 8'h25, 4'hA, 15, 4'h0};
      tbl[1] = '{4'h9, 8'h25, 4'h0,  7, 4'hA};
      tbl[2] = '{4'h6, 8'h30, 4'h7, 15, 4'h0};
      tbl[3] = '{4'hE, 8'h30, 4'h0,  7, 4'h7};
      tbl[4] = '{4'h9, 8'hC0, 4'h0, 15, 4'h0};
      tbl[5] = '{4'h9, 8'h25, 4'h0, 15, 4'hA};
      // {dbus_out, cm_ram, sync} for WRM 0x25/0xA: SRC cycle, then the IO cycle
      wave = '{{4'h0, 2'b00}, {4'h0, 2'b00}, {4'h0, 2'b00}, {4'h2, 2'b00},
               {4'h1, 2'b00}, {4'h0, 2'b00}, {4'h2, 2'b10}, {4'h5, 2'b01},
               {4'h0, 2'b00}, {4'h0, 2'b00}, {4'h0, 2'b00}, {4'hE, 2'b00},
               {4'h0, 2'b10}, {4'h0, 2'b00}, {4'hA, 2'b00}, {4'h0, 2'b01}};
      for (int d = 0; d < 2; d++) begin
         lv[d] = 1'b0;
         la[d] = 8'h00;
         for (int i = 0; i < 64; i++) em[d][i] = 4'h0;
         for (int i = 0; i < 16; i++) es[d][i] = 4'h0;
      end
      drive(0, 1'b0, 4'h0, 8'h00, 4'h0);

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_sync0", int'(if0.sync), 1);
      chk("rst_sync1", int'(if1.sync), 1);
      chk("rst_rsp_valid", int'(if0.rsp_valid), 0);
      chk("rst_rsp_rdata", int'(if0.rsp_rdata), 0);
      chk("rst_cm_ram", int'(if0.cm_ram), 0);
      rst = 1'b0;

      // Idle bus: sync every 8 clocks starting at release, nothing else driven.
      for (int j = 0; j < 17; j++) begin
         chk($sformatf("idle_sync_%0d", j), int'(if0.sync), int'(j % 8 == 0));
         chk($sformatf("idle_ready_%0d", j), int'(if0.cmd_ready), int'(j % 8 == 0));
         chk($sformatf("idle_bus_%0d", j), int'({if0.dbus_out, if0.cm_ram, if1.cm_ram}), 0);
         chk($sformatf("idle_sync1_%0d", j), int'(if1.sync), int'(j % 8 == 0));
         @(negedge clk);
      end

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 6; i++) begin
            void'(src_model(d, tbl[i].addr));
            void'(mdl(d, tbl[i].op, tbl[i].addr, tbl[i].wd));
            send(d, tbl[i].op, tbl[i].addr, tbl[i].wd, acc);
            if (d == 0 && i == 0) begin
               for (int j = 0; j < 16; j++) begin
                  chk($sformatf("wave_%0d", j), int'({if0.dbus_out, if0.cm_ram, if0.sync}),
                      int'(wave[j]));
                  @(negedge clk);
               end
            end
            if (acc >= 0)
               get_rsp(d, acc, (d == 0) ? tbl[i].lat : 15, tbl[i].rd,
                       $sformatf("tbl%0d_%0d", d, i), rc);
         end
      end

      // Four WRMs to an already-selected address with valid held high.
      for (int k = 0; k < 4; k++) begin
         int n;
         n = 0;
         void'(src_model(0, 8'h25));
         void'(mdl(0, 4'h0, 8'h25, 4'(k + 1)));
         drive(0, 1'b1, 4'h0, 8'h25, 4'(k + 1));
         while (!rdy(0) && n < 40) begin @(negedge clk); n++; end
         chk("b2b_ready", int'(rdy(0)), 1);
         accs[k] = cyc + 1;
         @(negedge clk);
      end
      drive(0, 1'b0, 4'h0, 8'h25, 4'h0);
      for (int k = 1; k < 4; k++) chk("b2b_accept_gap", accs[k] - accs[k-1], 8);
      prev_rc = 0;
      for (int k = 0; k < 4; k++) begin
         get_rsp(0, accs[k], 7, 4'h0, "b2b", rc);
         if (k > 0) chk("b2b_rsp_gap", rc - prev_rc, 8);
         prev_rc = rc;
      end
      do_cmd(0, 4'h9, 8'h25, 4'h0, "b2b_readback");

      // Reset in X1 of a cache-hit RDM: no response, and the SRC cache is forgotten.
      send(0, 4'h9, 8'h25, 4'h0, acc);
      repeat (4) @(negedge clk);
      chk("rst_seq_m2_cm_ram", int'(if0.cm_ram), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_seq_sync", int'(if0.sync), 1);
      chk("rst_seq_rsp_valid", int'(if0.rsp_valid), 0);
      @(negedge clk);
      chk("rst_seq_sync_held", int'(if0.sync), 1);
      rst = 1'b0;
      lv[0] = 1'b0;
      lv[1] = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_seq_no_rsp", qsize(0), 0);
      chk("rst_seq_rdata_cleared", int'(if0.rsp_rdata), 0);
      do_cmd(0, 4'h9, 8'h25, 4'h0, "rst_seq_src_reissue");

      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 3))
            0:       ra = 8'h25;
            1:       ra = 8'h30;
            2:       ra = 8'hC0;
            default: ra = 8'($urandom_range(0, 255));
         endcase
         do_cmd((i % 4 == 3) ? 1 : 0, 4'($urandom_range(0, 15)), ra,
                4'($urandom_range(0, 15)), $sformatf("rand%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
